// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: N-master round-robin Wishbone B3 arbiter with burst-safe ownership.
// Define WB_ARB_TIMEOUT_EN to add the stalled-slave timeout (ERR state, m_err_o).
module wb_rr_arbiter #(
   parameter int NUM_MASTERS = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 26,
   parameter int TIMEOUT     = 255
) (
   input  logic                                  wb_clk_i,
   input  logic                                  wb_rst_i,
   input  logic [NUM_MASTERS-1:0]                m_cyc_i,
   input  logic [NUM_MASTERS-1:0]                m_stb_i,
   input  logic [NUM_MASTERS-1:0]                m_we_i,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_addr_i,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_dat_i,
   input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]   m_sel_i,
   input  logic [NUM_MASTERS*3-1:0]              m_cti_i,
   output logic [DATA_WIDTH-1:0]                 m_dat_o,
   output logic [NUM_MASTERS-1:0]                m_ack_o,
   output logic [NUM_MASTERS-1:0]                m_err_o,
   output logic                                  s_cyc_o,
   output logic                                  s_stb_o,
   output logic                                  s_we_o,
   output logic [ADDR_WIDTH-1:0]                 s_addr_o,
   output logic [DATA_WIDTH-1:0]                 s_dat_o,
   output logic [DATA_WIDTH/8-1:0]               s_sel_o,
   output logic [2:0]                            s_cti_o,
   input  logic [DATA_WIDTH-1:0]                 s_dat_i,
   input  logic                                  s_ack_i,
   output logic [NUM_MASTERS-1:0]                grant_o
);
   localparam int IW = $clog2(NUM_MASTERS);
   localparam int SW = DATA_WIDTH / 8;
`ifdef WB_ARB_TIMEOUT_EN
   typedef enum logic [1:0] {IDLE, OWN, ERR} state_t;
`else
   typedef enum logic {IDLE, OWN} state_t;
`endif
   state_t                 state;
   logic [NUM_MASTERS-1:0] grant;
   logic [IW-1:0]          gidx, rr_ptr, win, k;
   logic                   own, timed_out;

   if (NUM_MASTERS < 2 || NUM_MASTERS > 16 || DATA_WIDTH % 8 != 0 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_params
      $error("wb_rr_arbiter: parameter out of range");
   end

   // Scan downward so the last hit is the requester closest above rr_ptr.
   always_comb begin
      win = rr_ptr;
      k = '0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         k = IW'((int'(rr_ptr) + i) % NUM_MASTERS);
         if (m_cyc_i[k]) win = k;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i)
      if (wb_rst_i) begin
         state  <= IDLE;
         grant  <= '0;
         gidx   <= '0;
         rr_ptr <= '0;
      end else
         case (state)
            IDLE:
               if (|m_cyc_i) begin
                  state  <= OWN;
                  grant  <= {{(NUM_MASTERS-1){1'b0}}, 1'b1} << win;
                  gidx   <= win;
                  rr_ptr <= (win == IW'(NUM_MASTERS - 1)) ? '0 : win + 1'b1;
               end
            OWN:
               if (!m_cyc_i[gidx]) begin
                  state <= IDLE;
                  grant <= '0;
               end else if (timed_out)
                  state <= state_t'(2);
            default: begin
               state <= IDLE;
               grant <= '0;
            end
         endcase

   assign own      = state == OWN;
   assign s_cyc_o  = own & m_cyc_i[gidx];
   assign s_stb_o  = own & m_cyc_i[gidx] & m_stb_i[gidx];
   assign s_we_o   = own & m_we_i[gidx];
   assign s_addr_o = own ? m_addr_i[gidx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
   assign s_dat_o  = own ? m_dat_i[gidx*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign s_sel_o  = own ? m_sel_i[gidx*SW +: SW] : '0;
   assign s_cti_o  = own ? m_cti_i[gidx*3 +: 3] : '0;
   assign m_dat_o  = s_dat_i;
   assign m_ack_o  = (s_ack_i & s_stb_o) ? grant : '0;
   assign grant_o  = grant;

`ifdef WB_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] stall_cnt;

   // Counter is zero whenever we are not in OWN, so a fresh grant starts clean.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i)
      if (wb_rst_i) stall_cnt <= '0;
      else stall_cnt <= (own && s_stb_o && !s_ack_i) ? stall_cnt + 1'b1 : '0;

   assign timed_out = stall_cnt == CW'(TIMEOUT);
   assign m_err_o   = (state == ERR) ? grant : '0;
`else
   assign timed_out = 1'b0;
   assign m_err_o   = '0;
`endif
endmodule
